// File: rtl/static_clock_divider_pow2.sv
// Static power-of-two clock divider: clk_out runs at f(clk)/2^N with exact 50 % duty,
// driven straight from the counter MSB so it cannot glitch.
module static_clock_divider_pow2 #(
    parameter int N = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic clk_out
);

    // Rejecting bad ratios at elaboration keeps N=0 from degenerating into a clock pass-through.
    generate
        if (N < 1 || N > 31) begin : g_bad_n
            $error("static_clock_divider_pow2: N=%0d outside legal range 1..31", N);
        end
    endgenerate

    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;

    // Natural modulo-2^N wrap; no terminal-count compare needed.
    always_comb begin
        cnt_d = cnt_q + N'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign clk_out = cnt_q[N-1];

endmodule

// File: tb/tb_static_clock_divider_pow2.sv
// Directed bench for static_clock_divider_pow2: N=1,2,3 instances share clk/rst_n and are
// checked against hand-written waveforms, async reset behaviour and phase alignment.
module tb_static_clock_divider_pow2;

    logic clk;
    logic rst_n;
    logic out_d2;
    logic out_d4;
    logic out_d8;

    int tests_run;
    int tests_failed;

    static_clock_divider_pow2 #(.N(1)) u_div2 (.clk(clk), .rst_n(rst_n), .clk_out(out_d2));
    static_clock_divider_pow2 #(.N(2)) u_div4 (.clk(clk), .rst_n(rst_n), .clk_out(out_d4));
    static_clock_divider_pow2 #(.N(3)) u_div8 (.clk(clk), .rst_n(rst_n), .clk_out(out_d8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected clk_out after edge k (k = 1..16), index 0 = edge 1.
    logic exp_d2 [16] = '{1,0,1,0, 1,0,1,0, 1,0,1,0, 1,0,1,0};
    logic exp_d4 [16] = '{0,1,1,0, 0,1,1,0, 0,1,1,0, 0,1,1,0};
    logic exp_d8 [16] = '{0,0,0,1, 1,1,1,0, 0,0,0,1, 1,1,1,0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            tests_run++;
            if ({out_d2, out_d4, out_d8} !== 3'b000) begin
                tests_failed++;
                $display("FAIL reset_hold cycle %0d: got d2=%b d4=%b d8=%b, want 0 0 0",
                         i, out_d2, out_d4, out_d8);
            end
        end
    endtask

    // Releases reset and checks all three waveforms plus phase alignment over 16 edges.
    task automatic test_divide_and_phase();
        logic p2, p4, p8;
        int rise_edge [$];
        int fall_edge [$];
        @(negedge clk);
        rst_n = 1'b1;
        p2 = out_d2;
        p4 = out_d4;
        p8 = out_d8;
        for (int k = 1; k <= 16; k++) begin
            step();
            tests_run++;
            if (out_d2 !== exp_d2[k-1]) begin
                tests_failed++;
                $display("FAIL div2 edge %0d: got %b, want %b", k, out_d2, exp_d2[k-1]);
            end
            tests_run++;
            if (out_d4 !== exp_d4[k-1]) begin
                tests_failed++;
                $display("FAIL div4 edge %0d: got %b, want %b", k, out_d4, exp_d4[k-1]);
            end
            tests_run++;
            if (out_d8 !== exp_d8[k-1]) begin
                tests_failed++;
                $display("FAIL div8 edge %0d: got %b, want %b", k, out_d8, exp_d8[k-1]);
            end
            if (p8 === 1'b0 && out_d8 === 1'b1) rise_edge.push_back(k);
            if (p8 === 1'b1 && out_d8 === 1'b0) begin
                fall_edge.push_back(k);
                tests_run++;
                if (!(p4 === 1'b1 && out_d4 === 1'b0 && p2 === 1'b1 && out_d2 === 1'b0)) begin
                    tests_failed++;
                    $display("FAIL phase_align edge %0d: d4 %b->%b d2 %b->%b, want both 1->0",
                             k, p4, out_d4, p2, out_d2);
                end
            end
            p2 = out_d2;
            p4 = out_d4;
            p8 = out_d8;
        end
        tests_run++;
        if (rise_edge.size() != 2 || fall_edge.size() != 2) begin
            tests_failed++;
            $display("FAIL div8_edges: got %0d rises %0d falls, want 2 and 2",
                     rise_edge.size(), fall_edge.size());
        end else begin
            tests_run++;
            if (rise_edge[1] - rise_edge[0] != 8) begin
                tests_failed++;
                $display("FAIL div8_period: got %0d, want 8", rise_edge[1] - rise_edge[0]);
            end
            tests_run++;
            if (fall_edge[0] - rise_edge[0] != 4) begin
                tests_failed++;
                $display("FAIL div8_high_time: got %0d, want 4", fall_edge[0] - rise_edge[0]);
            end
        end
    endtask

    // Counters wrapped to 0 after 16 edges; 5 more edges puts /8 mid-high-phase.
    task automatic test_async_reset_mid_high();
        int first_rise;
        for (int k = 1; k <= 5; k++) step();
        tests_run++;
        if (out_d8 !== 1'b1) begin
            tests_failed++;
            $display("FAIL pre_reset_high: got %b, want 1", out_d8);
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({out_d2, out_d4, out_d8} !== 3'b000 || clk !== 1'b1) begin
            tests_failed++;
            $display("FAIL async_reset: got d2=%b d4=%b d8=%b clk=%b, want 0 0 0 with clk still 1",
                     out_d2, out_d4, out_d8, clk);
        end
        step();
        @(negedge clk);
        rst_n = 1'b1;
        first_rise = 0;
        for (int k = 1; k <= 20 && first_rise == 0; k++) begin
            step();
            if (out_d8 === 1'b1) first_rise = k;
        end
        tests_run++;
        if (first_rise != 4) begin
            tests_failed++;
            $display("FAIL restart_first_rise: got edge %0d, want edge 4 (0 = none in 20)", first_rise);
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        test_reset();
        test_divide_and_phase();
        test_async_reset_mid_high();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
